// File: rtl/sub_layer_seq.sv
// sub_layer_seq: sequenced ASCON substitution layer.
// LANES sbox cells process LANES state columns per clock; the state
// register is substituted in place over 64/LANES RUN cycles.
// The sbox cell is included here so the design elaborates on its own.

// sbox: 5-bit ASCON S-box; bit 0 of the [0:4] vectors is the MSB.
module sbox (
   input  logic [0:4] sbox_i,
   output logic [0:4] sbox_o
);
   // Table lookup of the ASCON S-box
   always_comb begin
      sbox_o = 5'h00;
      case (sbox_i)
         5'h00: sbox_o = 5'h04;  5'h01: sbox_o = 5'h0B;
         5'h02: sbox_o = 5'h1F;  5'h03: sbox_o = 5'h14;
         5'h04: sbox_o = 5'h1A;  5'h05: sbox_o = 5'h15;
         5'h06: sbox_o = 5'h09;  5'h07: sbox_o = 5'h02;
         5'h08: sbox_o = 5'h1B;  5'h09: sbox_o = 5'h05;
         5'h0A: sbox_o = 5'h08;  5'h0B: sbox_o = 5'h12;
         5'h0C: sbox_o = 5'h1D;  5'h0D: sbox_o = 5'h03;
         5'h0E: sbox_o = 5'h06;  5'h0F: sbox_o = 5'h1C;
         5'h10: sbox_o = 5'h1E;  5'h11: sbox_o = 5'h13;
         5'h12: sbox_o = 5'h07;  5'h13: sbox_o = 5'h0E;
         5'h14: sbox_o = 5'h00;  5'h15: sbox_o = 5'h0D;
         5'h16: sbox_o = 5'h11;  5'h17: sbox_o = 5'h18;
         5'h18: sbox_o = 5'h10;  5'h19: sbox_o = 5'h0C;
         5'h1A: sbox_o = 5'h01;  5'h1B: sbox_o = 5'h19;
         5'h1C: sbox_o = 5'h16;  5'h1D: sbox_o = 5'h0A;
         5'h1E: sbox_o = 5'h0F;  5'h1F: sbox_o = 5'h17;
         default: sbox_o = 5'h00;
      endcase
   end
endmodule

module sub_layer_seq #(
   parameter int LANES = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [0:4][0:63]  state_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [0:4][0:63]  state_o
);

   // Only powers of two that divide 64 give an integral number of groups
   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
            LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
         $error("sub_layer_seq: LANES must be one of 1,2,4,8,16,32,64");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   // First column of the final group; 0 when LANES=64 (single group)
   localparam logic [5:0] LAST_COL = 6'(64 - LANES);
   // Advance computed in 7 bits so LANES=64 wraps cleanly to 0
   localparam logic [6:0] STEP     = 7'(LANES);

   fsm_t             fsm_q, fsm_d;
   logic [5:0]       col_q, col_d;
   logic [0:4][0:63] st_q, st_d;

   logic [5:0] lane_col [LANES];
   logic [0:4] lane_in  [LANES];
   logic [0:4] lane_out [LANES];

   // Each lane gathers one column of the current group and substitutes it.
   // col_q is always a multiple of LANES, so col_q+l never passes column 63.
   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign lane_col[l] = col_q + 6'(l);
         assign lane_in[l]  = {st_q[0][lane_col[l]], st_q[1][lane_col[l]],
                               st_q[2][lane_col[l]], st_q[3][lane_col[l]],
                               st_q[4][lane_col[l]]};
         sbox u_sbox (
            .sbox_i (lane_in[l]),
            .sbox_o (lane_out[l])
         );
      end
   endgenerate

   // Next-state logic: load on accepted start, substitute one group per RUN cycle
   always_comb begin
      fsm_d = fsm_q;
      col_d = col_q;
      st_d  = st_q;
      case (fsm_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               st_d  = state_i;
               col_d = 6'd0;
               fsm_d = S_RUN;
            end else begin
               fsm_d = S_IDLE;
            end
         end
         S_RUN: begin
            for (int l = 0; l < LANES; l++) begin
               for (int k = 0; k < 5; k++) begin
                  st_d[k][lane_col[l]] = lane_out[l][k];
               end
            end
            col_d = 6'(7'(col_q) + STEP);
            if (col_q == LAST_COL) begin
               fsm_d = S_DONE;
            end
         end
         default: begin
            fsm_d = S_IDLE;
            col_d = 6'd0;
         end
      endcase
   end

   // State register with synchronous reset; reset aborts any operation
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q <= S_IDLE;
         col_q <= 6'd0;
         st_q  <= '0;
      end else begin
         fsm_q <= fsm_d;
         col_q <= col_d;
         st_q  <= st_d;
      end
   end

   // Status flags are decoded straight from the FSM register
   assign ready_o = (fsm_q == S_IDLE) || (fsm_q == S_DONE);
   assign busy_o  = (fsm_q == S_RUN);
   assign done_o  = (fsm_q == S_DONE);
   assign state_o = st_q;

endmodule

// File: tb/tb_sub_layer_seq.sv
// Bench for sub_layer_seq: three instances (LANES=4, 1, 64) checked against
// a whole-state reference substitution built from the ASCON table.
module tb_sub_layer_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start [3];
   logic [0:4][0:63] st_in;
   logic rdy [3];
   logic bsy [3];
   logic dn  [3];
   logic [0:4][0:63] so [3];

   int vectors = 0;
   int miscompares = 0;

   localparam int LAN [3] = '{4, 1, 64};
   localparam logic [4:0] TBL [32] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

   always #5 clk = ~clk;

   sub_layer_seq #(.LANES(4)) u_l4 (
      .clock_i(clk), .reset_i(rst), .start_i(start[0]), .state_i(st_in),
      .ready_o(rdy[0]), .busy_o(bsy[0]), .done_o(dn[0]), .state_o(so[0]));
   sub_layer_seq #(.LANES(1)) u_l1 (
      .clock_i(clk), .reset_i(rst), .start_i(start[1]), .state_i(st_in),
      .ready_o(rdy[1]), .busy_o(bsy[1]), .done_o(dn[1]), .state_o(so[1]));
   sub_layer_seq #(.LANES(64)) u_l64 (
      .clock_i(clk), .reset_i(rst), .start_i(start[2]), .state_i(st_in),
      .ready_o(rdy[2]), .busy_o(bsy[2]), .done_o(dn[2]), .state_o(so[2]));

   // Reference: substitute every column of the state at once
   function automatic logic [0:4][0:63] ref_sub(input logic [0:4][0:63] s);
      logic [0:4][0:63] r;
      logic [4:0] v, o;
      r = '0;
      for (int j = 0; j < 64; j++) begin
         v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
         o = TBL[v];
         for (int k = 0; k < 5; k++) r[k][j] = o[4-k];
      end
      return r;
   endfunction

   function automatic logic [0:4][0:63] rand_state();
      logic [0:4][0:63] s;
      for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
      return s;
   endfunction

   // Start one operation on instance d; returns result at done_o and the
   // number of clock edges from acceptance to the done cycle (0 on timeout)
   task automatic run_op(input int d, input logic [0:4][0:63] s,
                         output logic [0:4][0:63] res, output int lat);
      bit found;
      @(negedge clk);
      st_in = s;
      start[d] = 1'b1;
      @(posedge clk);
      lat = 0;
      found = 0;
      while (!found && lat < 200) begin
         @(negedge clk);
         lat++;
         start[d] = 1'b0;
         if (dn[d] === 1'b1) found = 1;
      end
      res = so[d];
      if (!found) lat = 0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         vectors++;
         if (rdy[d] !== 1'b1 || bsy[d] !== 1'b0 || dn[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags[%0d]: ready=%b busy=%b done=%b, required 1 0 0",
                     d, rdy[d], bsy[d], dn[d]);
         end
         vectors++;
         if (so[d] !== '0) begin
            miscompares++;
            $display("FAIL reset_state[%0d]: got %h, required 0", d, so[d]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_zero;
      logic [0:4][0:63] res;
      int lat;
      run_op(0, '0, res, lat);
      vectors++;
      if (lat !== 17) begin
         miscompares++;
         $display("FAIL zero_latency: got %0d, required 17", lat);
      end
      vectors++;
      if (res[2] !== 64'hFFFF_FFFF_FFFF_FFFF || res[0] !== 64'h0 || res[1] !== 64'h0 ||
          res[3] !== 64'h0 || res[4] !== 64'h0) begin
         miscompares++;
         $display("FAIL zero_rows: got %h, required row2 all ones, others zero", res);
      end
   endtask

   task automatic test_ones;
      logic [0:4][0:63] res, s;
      int lat;
      for (int k = 0; k < 5; k++) s[k] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int d = 1; d < 3; d++) begin
         run_op(d, s, res, lat);
         vectors++;
         if (lat !== 64 / LAN[d] + 1) begin
            miscompares++;
            $display("FAIL ones_latency[L=%0d]: got %0d, required %0d", LAN[d], lat, 64 / LAN[d] + 1);
         end
         vectors++;
         if (res[1] !== 64'h0 || res[0] !== '1 || res[2] !== '1 || res[3] !== '1 || res[4] !== '1) begin
            miscompares++;
            $display("FAIL ones_rows[L=%0d]: got %h, required row1 zero, others ones", LAN[d], res);
         end
      end
   endtask

   task automatic test_exhaustive;
      logic [0:4][0:63] res, s, exp;
      logic [4:0] v;
      int lat;
      for (int j = 0; j < 64; j++) begin
         v = 5'(j % 32);
         for (int k = 0; k < 5; k++) s[k][j] = v[4-k];
      end
      exp = ref_sub(s);
      for (int d = 0; d < 3; d++) begin
         run_op(d, s, res, lat);
         vectors++;
         if (res !== exp || lat !== 64 / LAN[d] + 1) begin
            miscompares++;
            $display("FAIL exhaustive[L=%0d]: got %h lat %0d, required %h lat %0d",
                     LAN[d], res, lat, exp, 64 / LAN[d] + 1);
         end
      end
   endtask

   task automatic test_random;
      logic [0:4][0:63] res, s, exp;
      int lat;
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 3; n++) begin
            s = rand_state();
            exp = ref_sub(s);
            run_op(d, s, res, lat);
            vectors++;
            if (res !== exp || lat !== 64 / LAN[d] + 1) begin
               miscompares++;
               $display("FAIL random[L=%0d,%0d]: got %h lat %0d, required %h lat %0d",
                        LAN[d], n, res, lat, exp, 64 / LAN[d] + 1);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [0:4][0:63] a, b;
      int lat;
      bit found;
      a = rand_state();
      b = rand_state();
      @(negedge clk);
      st_in = a;
      start[0] = 1'b1;
      @(posedge clk);
      lat = 0;
      found = 0;
      // start stays high and state_i churns throughout RUN
      while (!found && lat < 200) begin
         @(negedge clk);
         lat++;
         if (dn[0] === 1'b1) found = 1;
         else st_in = rand_state();
      end
      vectors++;
      if (!found || lat !== 17 || so[0] !== ref_sub(a) || rdy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first: got %h lat %0d ready %b, required %h lat 17 ready 1",
                  so[0], lat, rdy[0], ref_sub(a));
      end
      st_in = b;
      @(posedge clk);
      lat = 0;
      found = 0;
      while (!found && lat < 200) begin
         @(negedge clk);
         lat++;
         start[0] = 1'b0;
         if (dn[0] === 1'b1) found = 1;
      end
      vectors++;
      if (!found || lat !== 17 || so[0] !== ref_sub(b)) begin
         miscompares++;
         $display("FAIL b2b_second: got %h lat %0d, required %h lat 17", so[0], lat, ref_sub(b));
      end
   endtask

   task automatic test_reset_mid_run;
      logic [0:4][0:63] res, s;
      int lat, ndone;
      @(negedge clk);
      st_in = rand_state();
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0 || so[0] !== '0) begin
         miscompares++;
         $display("FAIL abort_state: ready=%b busy=%b done=%b state=%h, required 1 0 0 0",
                  rdy[0], bsy[0], dn[0], so[0]);
      end
      rst = 1'b0;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (dn[0] === 1'b1) ndone++;
      end
      vectors++;
      if (ndone !== 0) begin
         miscompares++;
         $display("FAIL abort_no_done: got %0d done pulses, required 0", ndone);
      end
      s = rand_state();
      run_op(0, s, res, lat);
      vectors++;
      if (res !== ref_sub(s) || lat !== 17) begin
         miscompares++;
         $display("FAIL abort_restart: got %h lat %0d, required %h lat 17", res, lat, ref_sub(s));
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) start[d] = 1'b0;
      st_in = '0;
      test_reset();
      test_zero();
      test_ones();
      test_exhaustive();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
